// File: rtl/hamming_pkg.sv
// Shared types and layout helpers for the SEC-DED Hamming decoder.
// Positions that are powers of two hold Hamming parity; position 0 holds overall parity.
package hamming_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StOverall,
      StCorrect,
      StDone
   } state_e;

   function automatic logic is_pow2(input int unsigned pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   function automatic int unsigned code_w(input int unsigned data_w, input int unsigned par_w);
      return data_w + par_w + 1;
   endfunction

   // At most 32 parity positions can precede any data bit, so i+33 bounds the scan.
   function automatic int unsigned pos_of_data(input int unsigned i);
      int unsigned res;
      int unsigned cnt;
      res = 0;
      cnt = 0;
      for (int unsigned p = 1; p <= i + 33; p++) begin
         if (!is_pow2(p)) begin
            if (cnt == i) res = p;
            cnt++;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hamming_sat_counter.sv
// Saturating event counter; a clear takes priority over a same-cycle increment.
module hamming_sat_counter
   import hamming_pkg::*;
#(
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               clr,
   output logic [COUNT_W-1:0] count
);

   logic [COUNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + COUNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Sequential SEC-DED Hamming decoder: one parity group per cycle, then overall parity,
// then classification/correction, with valid/ready on both sides and saturating counters.
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int unsigned DATA_W  = 4,
   parameter int unsigned PAR_W   = 3,
   parameter int unsigned COUNT_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W+PAR_W:0]     code_in,
   input  logic                      mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         data_out,
   output logic [PAR_W-1:0]          syndrome,
   output logic                      single_err,
   output logic                      double_err,
   input  logic                      clr_cnt,
   output logic [COUNT_W-1:0]        corr_cnt,
   output logic [COUNT_W-1:0]        uncorr_cnt
);

   localparam int unsigned CodeW = code_w(DATA_W, PAR_W);
   localparam int unsigned IdxW  = (PAR_W > 1) ? $clog2(PAR_W) : 1;

   if (2 ** PAR_W < CodeW) begin : g_bad_params
      $error("PAR_W too small: 2**PAR_W must be >= DATA_W+PAR_W+1");
   end

   state_e             state_q, state_d;
   logic [CodeW-1:0]   code_q, code_d;
   logic               mode_q, mode_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic [PAR_W-1:0]   syn_q, syn_d;
   logic               ovf_q, ovf_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               single_q, single_d;
   logic               double_q, double_d;
   logic               valid_q, valid_d;

   logic [PAR_W-1:0][CodeW-1:0] grp_bits;
   logic [PAR_W-1:0]            grp_par;
   logic [CodeW-1:0]            code_fix;
   logic [DATA_W-1:0]           data_fix;
   logic                        syn_in_range;
   logic                        is_single;
   logic                        is_double;
   logic                        inc_corr;
   logic                        inc_uncorr;

   // Group j covers every code position whose index has bit j set.
   for (genvar j = 0; j < PAR_W; j++) begin : g_grp
      assign grp_bits[j][0] = 1'b0;
      for (genvar p = 1; p < CodeW; p++) begin : g_pos
         assign grp_bits[j][p] = (((p >> j) & 1) != 0) ? code_q[p] : 1'b0;
      end
      assign grp_par[j] = ^grp_bits[j];
   end

   assign syn_in_range = ({1'b0, syn_q} < (PAR_W + 1)'(CodeW));
   assign is_single    = ovf_q && syn_in_range;
   assign is_double    = (ovf_q && !syn_in_range) || (!ovf_q && (syn_q != '0));

   // A zero syndrome with bad overall parity flips bit 0, leaving the data untouched.
   always_comb begin
      code_fix = code_q;
      if (is_single) code_fix[syn_q] = ~code_q[syn_q];
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_data
      localparam int unsigned Pos = pos_of_data(i);
      assign data_fix[i] = code_fix[Pos];
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      syn_d      = syn_q;
      ovf_d      = ovf_q;
      data_d     = data_q;
      single_d   = single_q;
      double_d   = double_q;
      valid_d    = valid_q;
      inc_corr   = 1'b0;
      inc_uncorr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               code_d   = code_in;
               mode_d   = mode;
               syn_d    = '0;
               idx_d    = '0;
               ovf_d    = 1'b0;
               single_d = 1'b0;
               double_d = 1'b0;
               state_d  = StCheck;
            end
         end
         StCheck: begin
            syn_d[idx_q] = grp_par[idx_q] ^ ~mode_q;
            idx_d        = idx_q + IdxW'(1);
            if (idx_q == IdxW'(PAR_W - 1)) state_d = StOverall;
         end
         StOverall: begin
            ovf_d   = (^code_q) ^ ~mode_q;
            state_d = StCorrect;
         end
         StCorrect: begin
            data_d     = data_fix;
            single_d   = is_single;
            double_d   = is_double;
            inc_corr   = is_single;
            inc_uncorr = is_double;
            valid_d    = 1'b1;
            state_d    = StDone;
         end
         StDone: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         code_q   <= '0;
         mode_q   <= 1'b0;
         idx_q    <= '0;
         syn_q    <= '0;
         ovf_q    <= 1'b0;
         data_q   <= '0;
         single_q <= 1'b0;
         double_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         mode_q   <= mode_d;
         idx_q    <= idx_d;
         syn_q    <= syn_d;
         ovf_q    <= ovf_d;
         data_q   <= data_d;
         single_q <= single_d;
         double_q <= double_d;
         valid_q  <= valid_d;
      end
   end

   hamming_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_corr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_corr),
      .clr   (clr_cnt),
      .count (corr_cnt)
   );

   hamming_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_uncorr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_uncorr),
      .clr   (clr_cnt),
      .count (uncorr_cnt)
   );

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = valid_q;
   assign data_out   = data_q;
   assign syndrome   = syn_q;
   assign single_err = single_q;
   assign double_err = double_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (DATA_W=4, PAR_W=3, COUNT_W=2) with a result queue.
module tb_hamming_secded_decoder;

   localparam int unsigned DW = 4;
   localparam int unsigned PW = 3;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    code_in;
   logic          mode;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] data_out;
   logic [PW-1:0] syndrome;
   logic          single_err;
   logic          double_err;
   logic          clr_cnt;
   logic [CW-1:0] corr_cnt;
   logic [CW-1:0] uncorr_cnt;

   hamming_secded_decoder #(
      .DATA_W  (DW),
      .PAR_W   (PW),
      .COUNT_W (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .code_in    (code_in),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .syndrome   (syndrome),
      .single_err (single_err),
      .double_err (double_err),
      .clr_cnt    (clr_cnt),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] data;
      logic [2:0] syn;
      logic       se;
      logic       de;
      logic [1:0] corr;
      logic [1:0] unc;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   exp_corr = 0;
   int   exp_unc  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, req);
   endtask

   function automatic exp_t mk(input logic [3:0] d, input logic [2:0] s, input logic se,
                               input logic de);
      exp_t e;
      e.data = d;
      e.syn  = s;
      e.se   = se;
      e.de   = de;
      e.corr = '0;
      e.unc  = '0;
      return e;
   endfunction

   // Counter model: saturate at 3; a held clear zeroes both regardless of the result.
   task automatic send(input logic [7:0] code, input logic m, input exp_t e_in);
      exp_t e;
      int   guard;
      e = e_in;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_idle", in_ready, 1);
      if (clr_cnt) begin
         exp_corr = 0;
         exp_unc  = 0;
      end else begin
         if (e.se && exp_corr < 3) exp_corr++;
         if (e.de && exp_unc < 3) exp_unc++;
      end
      e.corr = 2'(exp_corr);
      e.unc  = 2'(exp_unc);
      code_in  = code;
      mode     = m;
      in_valid = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      mode     = ~m;
      code_in  = ~code;
   endtask

   task automatic collect(input string tag, input bit hold);
      int   lat;
      exp_t e;
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      // Accept edge + PAR_W+2 edges, observed on the following falling edge.
      check({tag, "_latency"}, lat, PW + 3);
      check({tag, "_valid"}, out_valid, 1);
      if (sb.size() != 0) e = sb.pop_front();
      else e = '0;
      check({tag, "_data"}, data_out, e.data);
      check({tag, "_syn"}, syndrome, e.syn);
      check({tag, "_flags"}, {single_err, double_err}, {e.se, e.de});
      check({tag, "_cnts"}, {corr_cnt, uncorr_cnt}, {e.corr, e.unc});
      check({tag, "_busy"}, in_ready, 0);
      if (hold) begin
         repeat (10) begin
            @(negedge clk);
            check({tag, "_hold"},
                  {out_valid, in_ready, data_out, syndrome, single_err, double_err},
                  {1'b1, 1'b0, e.data, e.syn, e.se, e.de});
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      bit   seen;
      logic [7:0] c;
      rst       = 1'b1;
      in_valid  = 1'b0;
      code_in   = '0;
      mode      = 1'b0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state",
            {in_ready, out_valid, data_out, syndrome, single_err, double_err, corr_cnt,
             uncorr_cnt}, {1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 2'h0, 2'h0});
      rst = 1'b0;

      // Reset while the word is in CHECK: nothing may emerge, counters stay untouched.
      @(negedge clk);
      code_in  = 8'h8A;
      mode     = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_reset_outputs",
            {in_ready, out_valid, data_out, syndrome, single_err, double_err, corr_cnt,
             uncorr_cnt}, {1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 2'h0, 2'h0});
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("mid_reset_no_output", seen, 0);
      check("mid_reset_counters", {corr_cnt, uncorr_cnt}, 4'h0);

      send(8'hAA, 1'b1, mk(4'hB, 3'd0, 1'b0, 1'b0));
      collect("clean_even", 1'b0);

      // Every single-bit flip, including the overall-parity bit 0.
      for (int p = 0; p < 8; p++) begin
         c = 8'hAA ^ (8'h01 << p);
         send(c, 1'b1, mk(4'hB, 3'(p), 1'b1, 1'b0));
         collect($sformatf("single_pos%0d", p), 1'b0);
      end
      check("corr_saturated", corr_cnt, 2'd3);

      send(8'hEE, 1'b1, mk(4'hF, 3'd4, 1'b0, 1'b1));
      collect("double_even", 1'b0);

      send(8'hBC, 1'b0, mk(4'hB, 3'd0, 1'b0, 1'b0));
      collect("clean_odd", 1'b0);
      send(8'hAA, 1'b0, mk(4'h3, 3'd7, 1'b1, 1'b0));
      collect("single_odd", 1'b0);

      clr_cnt = 1'b1;
      send(8'h8A, 1'b1, mk(4'hB, 3'd5, 1'b1, 1'b0));
      collect("clear_wins", 1'b0);
      clr_cnt = 1'b0;

      send(8'hAB, 1'b1, mk(4'hB, 3'd0, 1'b1, 1'b0));
      collect("backpressure", 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
